axi4_arbiter_2m: RTL

Two-master to one-slave AXI4 arbiter placed directly in front of the AXI4 BRAM slave. It lets two independent bus masters share the slave. Write (AW/W/B) and read (AR/R) directions are arbitrated independently with round-robin priority. A grant is held until the whole transaction completes.

---
 rtl/axi4_arb_pkg.sv | 24 ++
 rtl/axi4_rr_arb2.sv | 31 +++
 rtl/axi4_arbiter_2m.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/axi4_arb_pkg.sv
// Shared types and AXI codes for the two-master AXI4 arbiter.
package axi4_arb_pkg;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } r_state_t;

    localparam logic [1:0] FIXED  = 2'b00;
    localparam logic [1:0] INCR   = 2'b01;
    localparam logic [1:0] WRAP   = 2'b10;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;

endpackage

// File: rtl/axi4_rr_arb2.sv
// Two-requester round-robin picker; the last-granted bit advances only on accept.
module axi4_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic       gnt
);

    logic last_q;

    always_comb begin
        gnt = 1'b0;
        case (req)
            2'b10:   gnt = 1'b1;
            2'b11:   gnt = ~last_q;
            default: gnt = 1'b0;
        endcase
    end

    // Reset to 1 so M0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (accept) begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
            last_q <= gnt;
        end
    end

endmodule

// File: rtl/axi4_arbiter_2m.sv
// Two-master to one-slave AXI4 arbiter; write and read directions arbitrate independently
// and each grant is held until its transaction completes.
module axi4_arbiter_2m
    import axi4_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 1024,
    parameter int ADDR_WIDTH = $clog2(32 * DATA_WIDTH)
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    // Master 0
    input  logic [ADDR_WIDTH-1:0] M0_AWADDR,
    input  logic [1:0]            M0_AWBURST,
    input  logic [7:0]            M0_AWLEN,
    input  logic [2:0]            M0_AWSIZE,
    input  logic                  M0_AWVALID,
    output logic                  M0_AWREADY,
    input  logic [DATA_WIDTH-1:0] M0_WDATA,
    input  logic                  M0_WLAST,
    input  logic                  M0_WVALID,
    output logic                  M0_WREADY,
    output logic [1:0]            M0_BRESP,
    output logic                  M0_BVALID,
    input  logic                  M0_BREADY,
    input  logic [ADDR_WIDTH-1:0] M0_ARADDR,
    input  logic [1:0]            M0_ARBURST,
    input  logic [7:0]            M0_ARLEN,
    input  logic [2:0]            M0_ARSIZE,
    input  logic                  M0_ARVALID,
    output logic                  M0_ARREADY,
    output logic [DATA_WIDTH-1:0] M0_RDATA,
    output logic                  M0_RLAST,
    output logic                  M0_RVALID,
    output logic [1:0]            M0_RRESP,
    input  logic                  M0_RREADY,
    // Master 1
    input  logic [ADDR_WIDTH-1:0] M1_AWADDR,
    input  logic [1:0]            M1_AWBURST,
    input  logic [7:0]            M1_AWLEN,
    input  logic [2:0]            M1_AWSIZE,
    input  logic                  M1_AWVALID,
    output logic                  M1_AWREADY,
    input  logic [DATA_WIDTH-1:0] M1_WDATA,
    input  logic                  M1_WLAST,
    input  logic                  M1_WVALID,
    output logic                  M1_WREADY,
    output logic [1:0]            M1_BRESP,
    output logic                  M1_BVALID,
    input  logic                  M1_BREADY,
    input  logic [ADDR_WIDTH-1:0] M1_ARADDR,
    input  logic [1:0]            M1_ARBURST,
    input  logic [7:0]            M1_ARLEN,
    input  logic [2:0]            M1_ARSIZE,
    input  logic                  M1_ARVALID,
    output logic                  M1_ARREADY,
    output logic [DATA_WIDTH-1:0] M1_RDATA,
    output logic                  M1_RLAST,
    output logic                  M1_RVALID,
    output logic [1:0]            M1_RRESP,
    input  logic                  M1_RREADY,
    // Slave
    output logic [ADDR_WIDTH-1:0] S_AWADDR,
    output logic [1:0]            S_AWBURST,
    output logic [7:0]            S_AWLEN,
    output logic [2:0]            S_AWSIZE,
    output logic                  S_AWVALID,
    input  logic                  S_AWREADY,
    output logic [DATA_WIDTH-1:0] S_WDATA,
    output logic                  S_WLAST,
    output logic                  S_WVALID,
    input  logic                  S_WREADY,
    input  logic [1:0]            S_BRESP,
    input  logic                  S_BVALID,
    output logic                  S_BREADY,
    output logic [ADDR_WIDTH-1:0] S_ARADDR,
    output logic [1:0]            S_ARBURST,
    output logic [7:0]            S_ARLEN,
    output logic [2:0]            S_ARSIZE,
    output logic                  S_ARVALID,
    input  logic                  S_ARREADY,
    input  logic [DATA_WIDTH-1:0] S_RDATA,
    input  logic                  S_RLAST,
    input  logic                  S_RVALID,
    input  logic [1:0]            S_RRESP,
    output logic                  S_RREADY,
    // Status
    output logic                  W_GNT,
    output logic                  R_GNT,
    output logic                  W_BUSY,
    output logic                  R_BUSY
);

    w_state_t w_state_q, w_state_d;
    r_state_t r_state_q, r_state_d;
    logic     w_gnt_q, w_gnt_d;
    logic     r_gnt_q, r_gnt_d;
    logic     w_accept, r_accept;
    logic     w_pick, r_pick;

    axi4_rr_arb2 u_w_arb (
        .clk    (ACLK),
        .rst    (ARESET),
        .req    ({M1_AWVALID, M0_AWVALID}),
        .accept (w_accept),
        .gnt    (w_pick)
    );

    axi4_rr_arb2 u_r_arb (
        .clk    (ACLK),
        .rst    (ARESET),
        .req    ({M1_ARVALID, M0_ARVALID}),
        .accept (r_accept),
        .gnt    (r_pick)
    );

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            w_gnt_q   <= 1'b0;
            r_gnt_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            w_gnt_q   <= w_gnt_d;
            r_gnt_q   <= r_gnt_d;
        end
    end

    // Payloads follow the grant register so they settle before VALID opens.
    assign S_AWADDR  = w_gnt_q ? M1_AWADDR  : M0_AWADDR;
    assign S_AWBURST = w_gnt_q ? M1_AWBURST : M0_AWBURST;
    assign S_AWLEN   = w_gnt_q ? M1_AWLEN   : M0_AWLEN;
    assign S_AWSIZE  = w_gnt_q ? M1_AWSIZE  : M0_AWSIZE;
    assign S_WDATA   = w_gnt_q ? M1_WDATA   : M0_WDATA;
    assign S_WLAST   = w_gnt_q ? M1_WLAST   : M0_WLAST;
    assign S_ARADDR  = r_gnt_q ? M1_ARADDR  : M0_ARADDR;
    assign S_ARBURST = r_gnt_q ? M1_ARBURST : M0_ARBURST;
    assign S_ARLEN   = r_gnt_q ? M1_ARLEN   : M0_ARLEN;
    assign S_ARSIZE  = r_gnt_q ? M1_ARSIZE  : M0_ARSIZE;

    assign S_AWVALID = (w_state_q == W_ADDR) && (w_gnt_q ? M1_AWVALID : M0_AWVALID);
    assign S_WVALID  = (w_state_q == W_DATA) && (w_gnt_q ? M1_WVALID  : M0_WVALID);
    assign S_BREADY  = (w_state_q == W_RESP) && (w_gnt_q ? M1_BREADY  : M0_BREADY);
    assign S_ARVALID = (r_state_q == R_ADDR) && (r_gnt_q ? M1_ARVALID : M0_ARVALID);
    assign S_RREADY  = (r_state_q == R_DATA) && (r_gnt_q ? M1_RREADY  : M0_RREADY);

    assign M0_AWREADY = (w_state_q == W_ADDR) && !w_gnt_q && S_AWREADY;
    assign M1_AWREADY = (w_state_q == W_ADDR) &&  w_gnt_q && S_AWREADY;
    assign M0_WREADY  = (w_state_q == W_DATA) && !w_gnt_q && S_WREADY;
    assign M1_WREADY  = (w_state_q == W_DATA) &&  w_gnt_q && S_WREADY;
    assign M0_BVALID  = (w_state_q == W_RESP) && !w_gnt_q && S_BVALID;
    assign M1_BVALID  = (w_state_q == W_RESP) &&  w_gnt_q && S_BVALID;
    assign M0_ARREADY = (r_state_q == R_ADDR) && !r_gnt_q && S_ARREADY;
    assign M1_ARREADY = (r_state_q == R_ADDR) &&  r_gnt_q && S_ARREADY;
    assign M0_RVALID  = (r_state_q == R_DATA) && !r_gnt_q && S_RVALID;
    assign M1_RVALID  = (r_state_q == R_DATA) &&  r_gnt_q && S_RVALID;

    assign M0_BRESP = S_BRESP;
    assign M1_BRESP = S_BRESP;
    assign M0_RDATA = S_RDATA;
    assign M1_RDATA = S_RDATA;
    assign M0_RRESP = S_RRESP;
    assign M1_RRESP = S_RRESP;
    assign M0_RLAST = S_RLAST;
    assign M1_RLAST = S_RLAST;

    assign W_GNT  = w_gnt_q;
    assign R_GNT  = r_gnt_q;
    assign W_BUSY = (w_state_q != W_IDLE);
    assign R_BUSY = (r_state_q != R_IDLE);

    always_comb begin
        // NOTE: every variable gets a default first, so no branch can infer a latch.
        w_state_d = w_state_q;
        w_gnt_d   = w_gnt_q;
        w_accept  = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (M0_AWVALID || M1_AWVALID) begin
                    w_accept  = 1'b1;
                    w_gnt_d   = w_pick;
                    w_state_d = W_ADDR;
                end
            end
            W_ADDR:  if (S_AWVALID && S_AWREADY)           w_state_d = W_DATA;
            W_DATA:  if (S_WVALID && S_WREADY && S_WLAST)  w_state_d = W_RESP;
            W_RESP:  if (S_BVALID && S_BREADY)             w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        r_gnt_d   = r_gnt_q;
        r_accept  = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (M0_ARVALID || M1_ARVALID) begin
                    r_accept  = 1'b1;
                    r_gnt_d   = r_pick;
                    r_state_d = R_ADDR;
                end
            end
            R_ADDR:  if (S_ARVALID && S_ARREADY)           r_state_d = R_DATA;
            R_DATA:  if (S_RVALID && S_RREADY && S_RLAST)  r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

endmodule
